// File: rtl/seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// seq_detect_fsm
// Parametrised Moore sequence detector on a valid/ready symbol stream.
// A DEPTH-symbol pattern and a run mode are captured on start. Symbols are
// consumed while scanning. A completed pattern raises match for HOLD cycles,
// then the FSM either resumes scanning (continuous) or parks in DONE
// (single-shot) until clr.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     IDLE only: capture pat/mode, clear hit count, enter SCAN
//   clr       synchronous abort to IDLE (hit count and pattern retained)
//   mode      0 = single-shot, 1 = continuous (captured on start)
//   pat       DEPTH symbols, symbol 0 in the LSBs
//   in_valid  input symbol valid
//   in_sym    input symbol
//   in_ready  high only in SCAN
//   match     high only in HIT
//   done      high only in DONE
//   state     IDLE=00 SCAN=01 HIT=10 DONE=11
//   progress  pattern symbols matched so far
//   hit_cnt   hits since last start, saturating at all-ones
// -----------------------------------------------------------------------------
module seq_detect_fsm #(
   parameter int SYM_W = 3,
   parameter int DEPTH = 4,
   parameter int HOLD  = 2,
   parameter int CNT_W = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       clr,
   input  logic                       mode,
   input  logic [DEPTH*SYM_W-1:0]     pat,
   input  logic                       in_valid,
   input  logic [SYM_W-1:0]           in_sym,
   output logic                       in_ready,
   output logic                       match,
   output logic                       done,
   output logic [1:0]                 state,
   output logic [$clog2(DEPTH)-1:0]   progress,
   output logic [CNT_W-1:0]           hit_cnt
);

   localparam int PW = $clog2(DEPTH);
   localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SCAN = 2'b01,
      ST_HIT  = 2'b10,
      ST_DONE = 2'b11
   } state_t;

   state_t                   state_r, state_s;
   logic [PW-1:0]            prog_r, prog_s;
   logic [HW-1:0]            hold_r, hold_s;
   logic [CNT_W-1:0]         cnt_r, cnt_s;
   logic [DEPTH*SYM_W-1:0]   pat_r, pat_s;
   logic                     mode_r, mode_s;
   logic                     xfer_s;
   logic [SYM_W-1:0]         exp_sym_s;
   logic                     in_ready_r, match_r, done_r;

   // Handshake and the symbol the pattern expects next.
   always_comb begin
      xfer_s    = in_valid && (state_r == ST_SCAN);
      exp_sym_s = pat_r[32'(prog_r) * SYM_W +: SYM_W];
   end

   // Next-state logic: clr dominates, then per-state behaviour.
   always_comb begin
      state_s = state_r;
      prog_s  = prog_r;
      hold_s  = hold_r;
      cnt_s   = cnt_r;
      pat_s   = pat_r;
      mode_s  = mode_r;
      if (clr) begin
         state_s = ST_IDLE;
         prog_s  = {PW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  pat_s   = pat;
                  mode_s  = mode;
                  cnt_s   = {CNT_W{1'b0}};
                  prog_s  = {PW{1'b0}};
                  state_s = ST_SCAN;
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_SCAN: begin
               if (xfer_s) begin
                  if (in_sym == exp_sym_s) begin
                     if (prog_r == PW'(DEPTH - 1)) begin
                        state_s = ST_HIT;
                        hold_s  = HW'(HOLD - 1);
                        prog_s  = {PW{1'b0}};
                        if (cnt_r != {CNT_W{1'b1}}) begin
                           cnt_s = cnt_r + CNT_W'(1);
                        end else begin
                           cnt_s = cnt_r;
                        end
                     end else begin
                        prog_s = prog_r + PW'(1);
                     end
                  end else begin
                     // Simple restart: a mismatching symbol may itself begin a new attempt.
                     prog_s = (in_sym == pat_r[SYM_W-1:0]) ? PW'(1) : PW'(0);
                  end
               end else begin
                  state_s = ST_SCAN;
               end
            end
            ST_HIT: begin
               if (hold_r == HW'(0)) begin
                  if (mode_r) begin
                     state_s = ST_SCAN;
                  end else begin
                     state_s = ST_DONE;
                  end
               end else begin
                  hold_s = hold_r - HW'(1);
               end
            end
            ST_DONE: begin
               state_s = ST_DONE;
            end
            default: begin
               state_s = ST_IDLE;
               prog_s  = {PW{1'b0}};
            end
         endcase
      end
   end

   // State registers; status flags are registered from the next state so they track state_r exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         prog_r     <= {PW{1'b0}};
         hold_r     <= {HW{1'b0}};
         cnt_r      <= {CNT_W{1'b0}};
         pat_r      <= {(DEPTH*SYM_W){1'b0}};
         mode_r     <= 1'b0;
         in_ready_r <= 1'b0;
         match_r    <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         prog_r     <= prog_s;
         hold_r     <= hold_s;
         cnt_r      <= cnt_s;
         pat_r      <= pat_s;
         mode_r     <= mode_s;
         in_ready_r <= (state_s == ST_SCAN);
         match_r    <= (state_s == ST_HIT);
         done_r     <= (state_s == ST_DONE);
      end
   end

   assign in_ready = in_ready_r;
   assign match    = match_r;
   assign done     = done_r;
   assign state    = state_r;
   assign progress = prog_r;
   assign hit_cnt  = cnt_r;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_fsm
// Directed scenarios plus randomized stimulus for seq_detect_fsm, checked
// every cycle against a behavioural reference model. Two instances share the
// stimulus: one with an 8-bit hit counter, one with a 2-bit counter to
// exercise saturation.
// -----------------------------------------------------------------------------
module tb_seq_detect_fsm;

   localparam int SYM_W = 3;
   localparam int DEPTH = 4;
   localparam int HOLD  = 2;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start, clr, mode, in_valid;
   logic [DEPTH*SYM_W-1:0] pat;
   logic [SYM_W-1:0]       in_sym;

   logic       a_in_ready, a_match, a_done;
   logic [1:0] a_state, a_progress;
   logic [7:0] a_hit_cnt;
   logic       b_in_ready, b_match, b_done;
   logic [1:0] b_state, b_progress;
   logic [1:0] b_hit_cnt;

   seq_detect_fsm #(.SYM_W(SYM_W), .DEPTH(DEPTH), .HOLD(HOLD), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .clr(clr), .mode(mode), .pat(pat),
      .in_valid(in_valid), .in_sym(in_sym), .in_ready(a_in_ready), .match(a_match),
      .done(a_done), .state(a_state), .progress(a_progress), .hit_cnt(a_hit_cnt)
   );

   seq_detect_fsm #(.SYM_W(SYM_W), .DEPTH(DEPTH), .HOLD(HOLD), .CNT_W(2)) u_sat (
      .clk(clk), .reset(reset), .start(start), .clr(clr), .mode(mode), .pat(pat),
      .in_valid(in_valid), .in_sym(in_sym), .in_ready(b_in_ready), .match(b_match),
      .done(b_done), .state(b_state), .progress(b_progress), .hit_cnt(b_hit_cnt)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: phase 0 idle, 1 scanning, 2 flagging a hit, 3 finished.
   int m_st, m_prog, m_left, m_hits, m_mode;
   int m_pat [DEPTH];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      if (obs !== exp_v) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_prog = 0; m_left = 0; m_hits = 0; m_mode = 0;
      for (int i = 0; i < DEPTH; i++) m_pat[i] = 0;
   endtask

   task automatic model_step(input logic st, input logic cl, input logic md,
                             input logic v, input logic [SYM_W-1:0] sym);
      if (cl) begin
         m_st = 0; m_prog = 0;
      end else if (m_st == 0) begin
         if (st) begin
            for (int i = 0; i < DEPTH; i++) m_pat[i] = int'((pat >> (SYM_W * i)) & 12'd7);
            m_mode = int'(md); m_hits = 0; m_prog = 0; m_st = 1;
         end
      end else if (m_st == 1) begin
         if (v) begin
            if (int'(sym) == m_pat[m_prog]) begin
               if (m_prog == DEPTH - 1) begin
                  m_st = 2; m_left = HOLD; m_prog = 0; m_hits++;
               end else begin
                  m_prog++;
               end
            end else begin
               m_prog = (int'(sym) == m_pat[0]) ? 1 : 0;
            end
         end
      end else if (m_st == 2) begin
         m_left--;
         if (m_left == 0) m_st = (m_mode != 0) ? 1 : 3;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".state"},    32'(a_state),    32'(m_st));
      check({tag, ".ready"},    32'(a_in_ready), 32'(m_st == 1));
      check({tag, ".match"},    32'(a_match),    32'(m_st == 2));
      check({tag, ".done"},     32'(a_done),     32'(m_st == 3));
      check({tag, ".progress"}, 32'(a_progress), 32'(m_prog));
      check({tag, ".hits"},     32'(a_hit_cnt),  32'((m_hits > 255) ? 255 : m_hits));
      check({tag, ".sat_hits"}, 32'(b_hit_cnt),  32'((m_hits > 3) ? 3 : m_hits));
      check({tag, ".sat_state"},32'(b_state),    32'(m_st));
   endtask

   task automatic step(input logic st, input logic cl, input logic md, input logic v,
                       input logic [SYM_W-1:0] sym, input string tag);
      @(negedge clk);
      start = st; clr = cl; mode = md; in_valid = v; in_sym = sym;
      @(posedge clk);
      model_step(st, cl, md, v, sym);
      #1;
      compare_all(tag);
   endtask

   // Feed n whole patterns with in_valid held high, advancing only on accepted symbols.
   task automatic stream(input string tag, input int n, input logic md);
      int idx = 0;
      int got = 0;
      int k   = 0;
      bit took;
      while (got < n && k < 200) begin
         took = (m_st == 1);
         step(1'b0, 1'b0, md, 1'b1, SYM_W'(m_pat[idx]), tag);
         if (took) begin
            idx++;
            if (idx == DEPTH) begin
               idx = 0;
               got++;
            end
         end
         k++;
      end
      check({tag, ".budget"}, 32'(got), 32'(n));
   endtask

   int seq3 [6] = '{1, 2, 1, 2, 3, 4};
   int seq4s [7] = '{1, 4, 2, 4, 3, 4, 4};
   int seq4v [7] = '{1, 0, 1, 0, 1, 0, 1};

   initial begin
      reset = 1'b0; start = 1'b0; clr = 1'b0; mode = 1'b0; in_valid = 1'b0;
      in_sym = '0; pat = {3'd4, 3'd3, 3'd2, 3'd1};
      model_reset();
      #12;
      compare_all("reset");
      @(negedge clk);
      reset = 1'b1;

      // Reset mid-scan with progress 2.
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, "t1_start");
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, "t1_s1");
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, "t1_s2");
      @(negedge clk);
      reset = 1'b0;
      #1;
      model_reset();
      compare_all("t1_async_rst");
      #2 reset = 1'b1;

      // Continuous mode, one full pattern.
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, "t2_start");
      stream("t2", 1, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, "t2_idle");
      check("t2_hit_cnt", 32'(a_hit_cnt), 32'd1);
      check("t2_back_scan", 32'(a_state), 32'd1);

      // Single-shot with restart on a mismatch that begins a new attempt.
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t3_clr");
      step(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, "t3_start");
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, SYM_W'(seq3[i]), "t3_seq");
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 3'd1, "t3_wait");
      check("t3_done", 32'(a_done), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, "t3_clr_out");
      check("t3_done_clr", 32'(a_done), 32'd0);

      // clr and start together in IDLE: stay IDLE.
      step(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, "clr_start");

      // in_valid toggling: unaccepted symbols must not advance or disturb progress.
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, "t4_start");
      for (int i = 0; i < 7; i++)
         step(1'b0, 1'b0, 1'b1, seq4v[i] != 0, SYM_W'(seq4s[i]), "t4_seq");
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "t4_idle");

      // Five back-to-back patterns, counter saturation on the narrow instance.
      step(1'b0, 1'b1, 1'b1, 1'b0, 3'd0, "t5_clr");
      step(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, "t5_start");
      stream("t5", 5, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, "t5_tail");
      check("t5_sat", 32'(b_hit_cnt), 32'd3);
      check("t5_wide", 32'(a_hit_cnt), 32'd5);

      // clr coinciding with the final matching symbol.
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd1, "t6_s1");
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, "t6_s2");
      step(1'b0, 1'b0, 1'b1, 1'b1, 3'd3, "t6_s3");
      step(1'b0, 1'b1, 1'b1, 1'b1, 3'd4, "t6_clr4");
      check("t6_idle", 32'(a_state), 32'd0);
      check("t6_hits_kept", 32'(a_hit_cnt), 32'd5);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 3'd4, "t6_after");

      // Randomized phase; pat changes every cycle so only the start-time value may matter.
      for (int n = 0; n < 1500; n++) begin
         logic st, cl, md, v;
         logic [SYM_W-1:0] sym;
         pat = 12'($urandom);
         st  = ($urandom_range(0, 7) == 0);
         cl  = ($urandom_range(0, 63) == 0);
         md  = 1'($urandom);
         v   = ($urandom_range(0, 3) != 0);
         if (m_st == 1 && $urandom_range(0, 3) != 0)
            sym = SYM_W'(m_pat[m_prog]);
         else
            sym = SYM_W'($urandom);
         step(st, cl, md, v, sym, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
